// File: rtl/lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_seq_ctrl
//   Sequencing controller for a reconfigurable LFSR datapath. A run request
//   (taps, seed, step count) is taken over a valid/ready handshake; the
//   controller then loads the LFSR, steps it exactly `count` times, measures
//   the period (first return to the seed) and reports status with a one-cycle
//   done pulse. Illegal configs, lockup (all-zero state) and abort end a run
//   early.
//
// Ports
//   clk, reset          clock; synchronous active-low reset
//   cfg_valid/ready     run request handshake (ready only in IDLE)
//   cfg_taps/seed/count request payload
//   abort               terminate the current run (LOAD or RUN)
//   lfsr_load/enable    load strobe / step enable to the LFSR
//   lfsr_seed/taps      captured seed/taps, stable between accepts
//   lfsr_state          current LFSR register value
//   busy, done          in LOAD/RUN; one-cycle completion pulse
//   steps_done, period, period_valid   run results
//   cfg_err, lockup_err, aborted       run status flags
// -----------------------------------------------------------------------------
module lfsr_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_taps,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             abort,
    output logic             lfsr_load,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic [WIDTH-1:0] lfsr_taps,
    output logic             lfsr_enable,
    input  logic [WIDTH-1:0] lfsr_state,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_done,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             cfg_err,
    output logic             lockup_err,
    output logic             aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] taps_q, taps_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pvalid_q, pvalid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             lockup_q, lockup_d;
    logic             aborted_q, aborted_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            seed_q    <= '0;
            taps_q    <= '0;
            count_q   <= '0;
            steps_q   <= '0;
            period_q  <= '0;
            pvalid_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            lockup_q  <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            taps_q    <= taps_d;
            count_q   <= count_d;
            steps_q   <= steps_d;
            period_q  <= period_d;
            pvalid_q  <= pvalid_d;
            cfg_err_q <= cfg_err_d;
            lockup_q  <= lockup_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        taps_d      = taps_q;
        count_d     = count_q;
        steps_d     = steps_q;
        period_d    = period_q;
        pvalid_d    = pvalid_q;
        cfg_err_d   = cfg_err_q;
        lockup_d    = lockup_q;
        aborted_d   = aborted_q;
        lfsr_load   = 1'b0;
        lfsr_enable = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort has no meaning here; only a request moves us on
                if (cfg_valid) begin
                    taps_d    = cfg_taps;
                    seed_d    = cfg_seed;
                    count_d   = cfg_count;
                    steps_d   = '0;
                    period_d  = '0;
                    pvalid_d  = 1'b0;
                    cfg_err_d = 1'b0;
                    lockup_d  = 1'b0;
                    aborted_d = 1'b0;
                    if (cfg_seed == '0 || cfg_taps == '0) begin
                        cfg_err_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    lfsr_load = 1'b1;
                    state_d   = (count_q == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                // Period: first cycle after at least one step where the
                // register is back at the seed. Later matches are ignored.
                if (lfsr_state == seed_q && steps_q != '0 && !pvalid_q) begin
                    period_d = steps_q;
                    pvalid_d = 1'b1;
                end
                // Priority: abort > lockup > count completion
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (lfsr_state == '0) begin
                    lockup_d = 1'b1;
                    state_d  = S_DONE;
                end else if (steps_q < count_q) begin
                    lfsr_enable = 1'b1;
                    steps_d     = steps_q + CNT_W'(1);
                    if (steps_d == count_q)
                        state_d = S_DONE;
                end else begin
                    // unreachable with count>0 entering RUN; keeps the FSM safe
                    state_d = S_DONE;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    assign cfg_ready    = (state_q == S_IDLE);
    assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done         = (state_q == S_DONE);
    assign lfsr_seed    = seed_q;
    assign lfsr_taps    = taps_q;
    assign steps_done   = steps_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;
    assign cfg_err      = cfg_err_q;
    assign lockup_err   = lockup_q;
    assign aborted      = aborted_q;

endmodule
